// File: rtl/sensor_deser.sv
`default_nettype none
// ============================================================================
// Module   : sensor_deser
// Purpose  : Dual-lane serial sensor deserialiser with sync-word framing and
//            a 2-entry AXI4-Stream output FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_deser #(
    parameter int          PIXEL_WIDTH = 14,
    parameter int          LINE_PAIRS  = 80,
    parameter int          FRAME_LINES = 120,
    parameter logic [15:0] SYNC_SOF    = 16'hFFF0,
    parameter logic [15:0] SYNC_SOL    = 16'hFFE0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        sensor_ena,
    input  logic        sample_ena,
    input  logic        sensor_data_even,
    input  logic        sensor_data_odd,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic [7:0]  line_cnt,
    output logic        frame_done,
    output logic        overflow,
    output logic        trunc,
    input  logic        err_clr
);

    localparam int             BW        = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
    localparam int             PCW       = (LINE_PAIRS > 1) ? $clog2(LINE_PAIRS) : 1;
    localparam logic [BW-1:0]  BIT_LAST  = BW'(PIXEL_WIDTH - 1);
    localparam logic [PCW-1:0] PAIR_LAST = PCW'(LINE_PAIRS - 1);
    localparam logic [7:0]     LINE_LAST = 8'(FRAME_LINES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HUNT    = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Assertion passes straight through; release is delayed two aclk edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    state_t           state_q, state_d;
    logic [15:0]      sh_even_q, sh_even_d, sh_odd_q, sh_odd_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PCW-1:0]   pair_cnt_q, pair_cnt_d;
    logic [7:0]       line_cnt_q, line_cnt_d;
    logic             tuser_pend_q, tuser_pend_d;
    logic             frame_done_q, frame_done_d;
    logic             overflow_q, overflow_d;
    logic             trunc_q, trunc_d;
    logic [33:0]      mem_q [2];
    logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             wr_req, push, pop;
    logic [33:0]      wr_entry;

    always_comb begin
        state_d      = state_q;
        sh_even_d    = sh_even_q;
        sh_odd_d     = sh_odd_q;
        bit_cnt_d    = bit_cnt_q;
        pair_cnt_d   = pair_cnt_q;
        line_cnt_d   = line_cnt_q;
        tuser_pend_d = tuser_pend_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q & ~err_clr;
        trunc_d      = trunc_q & ~err_clr;
        wr_req       = 1'b0;
        wr_entry     = '0;

        if (sample_ena && state_q != ST_IDLE) begin
            sh_even_d = {sh_even_q[14:0], sensor_data_even};
            sh_odd_d  = {sh_odd_q[14:0], sensor_data_odd};
        end

        unique case (state_q)
            ST_IDLE: begin
                sh_even_d    = '0;
                sh_odd_d     = '0;
                bit_cnt_d    = '0;
                pair_cnt_d   = '0;
                tuser_pend_d = 1'b0;
                if (sensor_ena) state_d = ST_HUNT;
            end
            ST_HUNT: begin
                if (!sensor_ena) begin
                    state_d = ST_IDLE;
                end else if (sample_ena) begin
                    if (sh_even_d == SYNC_SOF && sh_odd_d == SYNC_SOF) begin
                        state_d      = ST_PAYLOAD;
                        line_cnt_d   = '0;
                        tuser_pend_d = 1'b1;
                        bit_cnt_d    = '0;
                        pair_cnt_d   = '0;
                    end else if (sh_even_d == SYNC_SOL && sh_odd_d == SYNC_SOL) begin
                        state_d    = ST_PAYLOAD;
                        bit_cnt_d  = '0;
                        pair_cnt_d = '0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!sensor_ena) begin
                    state_d = ST_IDLE;
                    trunc_d = 1'b1;
                end else if (sample_ena) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d    = '0;
                        wr_req       = 1'b1;
                        wr_entry     = {tuser_pend_q, (pair_cnt_q == PAIR_LAST),
                                        16'(sh_odd_d[PIXEL_WIDTH-1:0]),
                                        16'(sh_even_d[PIXEL_WIDTH-1:0])};
                        tuser_pend_d = 1'b0;
                        if (pair_cnt_q == PAIR_LAST) begin
                            pair_cnt_d = '0;
                            state_d    = ST_HUNT;
                            if (line_cnt_q == LINE_LAST) begin
                                line_cnt_d   = '0;
                                frame_done_d = 1'b1;
                            end else begin
                                line_cnt_d = line_cnt_q + 8'd1;
                            end
                        end else begin
                            pair_cnt_d = pair_cnt_q + 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A full FIFO still accepts the write when the head leaves this cycle.
        pop  = (count_q != 2'd0) && m_axis_tready;
        push = wr_req && ((count_q != 2'd2) || pop);
        if (wr_req && !push) overflow_d = 1'b1;

        wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sh_even_q    <= '0;
            sh_odd_q     <= '0;
            bit_cnt_q    <= '0;
            pair_cnt_q   <= '0;
            line_cnt_q   <= '0;
            tuser_pend_q <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            trunc_q      <= 1'b0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
        end else begin
            state_q      <= state_d;
            sh_even_q    <= sh_even_d;
            sh_odd_q     <= sh_odd_d;
            bit_cnt_q    <= bit_cnt_d;
            pair_cnt_q   <= pair_cnt_d;
            line_cnt_q   <= line_cnt_d;
            tuser_pend_q <= tuser_pend_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            trunc_q      <= trunc_d;
            if (push) mem_q[wr_ptr_q] <= wr_entry;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    assign m_axis_tvalid = (count_q != 2'd0);
    assign m_axis_tuser  = mem_q[rd_ptr_q][33];
    assign m_axis_tlast  = mem_q[rd_ptr_q][32];
    assign m_axis_tdata  = mem_q[rd_ptr_q][31:0];
    assign line_cnt      = line_cnt_q;
    assign frame_done    = frame_done_q;
    assign overflow      = overflow_q;
    assign trunc         = trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_deser
// Purpose  : Self-checking bench for sensor_deser (shortened frame height).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_deser;

    localparam int          PW  = 14;
    localparam int          LP  = 80;
    localparam int          FL  = 8;
    localparam logic [15:0] SOF = 16'hFFF0;
    localparam logic [15:0] SOL = 16'hFFE0;

    logic        aclk = 1'b0;
    logic        aresetn, sensor_ena, sample_ena, sensor_data_even, sensor_data_odd;
    logic        m_axis_tready, err_clr;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tuser, m_axis_tlast, frame_done, overflow, trunc;
    logic [7:0]  line_cnt;

    sensor_deser #(
        .PIXEL_WIDTH (PW),
        .LINE_PAIRS  (LP),
        .FRAME_LINES (FL),
        .SYNC_SOF    (SOF),
        .SYNC_SOL    (SOL)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .sensor_ena       (sensor_ena),
        .sample_ena       (sample_ena),
        .sensor_data_even (sensor_data_even),
        .sensor_data_odd  (sensor_data_odd),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tuser     (m_axis_tuser),
        .m_axis_tlast     (m_axis_tlast),
        .line_cnt         (line_cnt),
        .frame_done       (frame_done),
        .overflow         (overflow),
        .trunc            (trunc),
        .err_clr          (err_clr)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad   = 0;
    int          fd_cnt = 0;
    int          got_base = 0;
    int          gap_max = 0;
    logic [33:0] got_q [$];
    logic [33:0] exp_q [$];
    logic [13:0] ev_a [LP];
    logic [13:0] od_a [LP];

    // Beats handshake on the next rising edge; sampled half a cycle early.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready)
            got_q.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
        if (frame_done) fd_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] e, input logic [15:0] o, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            sensor_data_even = e[i];
            sensor_data_odd  = o[i];
            sample_ena       = 1'b1;
            tick();
            sample_ena = 1'b0;
            repeat ($urandom_range(0, gap_max)) tick();
        end
    endtask

    task automatic send_pair(input int p);
        send_bits({2'b00, ev_a[p]}, {2'b00, od_a[p]}, PW);
    endtask

    task automatic send_line(input logic [15:0] sync);
        send_bits(sync, sync, 16);
        for (int p = 0; p < LP; p++) send_pair(p);
    endtask

    // A trailing 1 on both lanes followed by SOL reads as SOF one bit early,
    // so the last odd pixel of each random line ends in 0.
    task automatic fill_random();
        for (int p = 0; p < LP; p++) begin
            ev_a[p] = 14'($urandom);
            od_a[p] = 14'($urandom);
        end
        od_a[LP-1][0] = 1'b0;
    endtask

    task automatic model_pairs(input bit sof, input int npairs, input bit full_line);
        for (int p = 0; p < npairs; p++)
            exp_q.push_back({sof && (p == 0), full_line && (p == LP - 1),
                             2'b00, od_a[p], 2'b00, ev_a[p]});
    endtask

    task automatic compare_beats(input string tag);
        int n;
        n = got_q.size() - got_base;
        check({tag, "_count"}, 34'(n), 34'(exp_q.size()));
        for (int i = 0; i < n && i < exp_q.size(); i++)
            check(tag, got_q[got_base + i], exp_q[i]);
        got_base = got_q.size();
        exp_q.delete();
    endtask

    initial begin
        int frame_base;
        int fd0;
        int tl;

        aresetn = 1'b0; sensor_ena = 1'b0; sample_ena = 1'b0;
        sensor_data_even = 1'b0; sensor_data_odd = 1'b0;
        m_axis_tready = 1'b1; err_clr = 1'b0;
        repeat (3) tick();

        check("rst_tvalid", 34'(m_axis_tvalid), 34'd0);
        check("rst_tdata",  34'(m_axis_tdata),  34'd0);
        check("rst_tuser",  34'(m_axis_tuser),  34'd0);
        check("rst_tlast",  34'(m_axis_tlast),  34'd0);
        check("rst_line",   34'(line_cnt),      34'd0);
        check("rst_fdone",  34'(frame_done),    34'd0);
        check("rst_ovf",    34'(overflow),      34'd0);
        check("rst_trunc",  34'(trunc),         34'd0);

        aresetn = 1'b1;
        repeat (4) tick();

        // Directed first line: known ramp pattern.
        sensor_ena = 1'b1;
        repeat (2) tick();
        frame_base = got_base;
        fd0 = fd_cnt;
        for (int p = 0; p < LP; p++) begin
            ev_a[p] = 14'(p + 1);
            od_a[p] = 14'(16'h1000 + p + 1);
        end
        model_pairs(1'b1, LP, 1'b1);
        send_line(SOF);
        repeat (4) tick();
        check("beat0",  got_q[got_base],          {1'b1, 1'b0, 32'h1001_0001});
        check("beat79", got_q[got_base + LP - 1], {1'b0, 1'b1, 32'h1050_0050});
        compare_beats("ramp");
        check("line_after_0", 34'(line_cnt), 34'd1);

        // Remainder of the frame with random data and random bit gaps.
        gap_max = 2;
        for (int l = 1; l < FL; l++) begin
            fill_random();
            model_pairs(1'b0, LP, 1'b1);
            send_line(SOL);
        end
        repeat (4) tick();
        compare_beats("frame");
        tl = 0;
        for (int i = frame_base; i < got_q.size(); i++) tl += int'(got_q[i][32]);
        check("frame_tlast", 34'(tl), 34'(FL));
        check("frame_done_cnt", 34'(fd_cnt - fd0), 34'd1);
        check("line_wrap", 34'(line_cnt), 34'd0);

        // SOL after wrap without a fresh SOF.
        fill_random();
        model_pairs(1'b0, LP, 1'b1);
        send_line(SOL);
        repeat (4) tick();
        compare_beats("sol_wrap");
        check("line_after_wrap", 34'(line_cnt), 34'd1);

        // Back-pressure: three pairs complete with tready low.
        gap_max = 0;
        fill_random();
        send_bits(SOF, SOF, 16);
        m_axis_tready = 1'b0;
        send_pair(0); send_pair(1); send_pair(2);
        send_bits({2'b00, ev_a[3]}, {2'b00, od_a[3]}, 8);
        check("stall_tvalid", 34'(m_axis_tvalid), 34'd1);
        check("stall_tdata",  34'(m_axis_tdata), 34'({2'b00, od_a[0], 2'b00, ev_a[0]}));
        check("stall_ovf",    34'(overflow), 34'd1);
        check("stall_trunc",  34'(trunc), 34'd0);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("ovf_cleared", 34'(overflow), 34'd0);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        model_pairs(1'b1, 2, 1'b0);
        compare_beats("stall_drain");
        sensor_ena = 1'b0; err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("trunc_prio", 34'(trunc), 34'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("trunc_cleared", 34'(trunc), 34'd0);

        // Lane mismatch on the sync word must not lock.
        sensor_ena = 1'b1;
        repeat (2) tick();
        send_bits(SOF, 16'h0000, 16);
        repeat (3) send_bits(16'h0000, 16'h0000, 16);
        repeat (3) tick();
        check("mismatch_tvalid", 34'(m_axis_tvalid), 34'd0);
        compare_beats("mismatch");

        // Readout dropped mid-pixel in pair 10.
        gap_max = 1;
        fill_random();
        send_bits(SOF, SOF, 16);
        for (int p = 0; p < 10; p++) send_pair(p);
        send_bits({2'b00, ev_a[10]}, {2'b00, od_a[10]}, 7);
        sensor_ena = 1'b0;
        tick();
        check("drop_trunc", 34'(trunc), 34'd1);
        repeat (3) tick();
        model_pairs(1'b1, 10, 1'b0);
        compare_beats("drop");
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        sensor_ena = 1'b1;
        repeat (2) tick();
        fill_random();
        model_pairs(1'b1, LP, 1'b1);
        send_line(SOF);
        repeat (4) tick();
        compare_beats("restart");
        check("restart_line", 34'(line_cnt), 34'd1);
        check("restart_trunc", 34'(trunc), 34'd0);

        // Asynchronous reset while a beat is pending.
        gap_max = 0;
        fill_random();
        m_axis_tready = 1'b0;
        send_bits(SOF, SOF, 16);
        send_pair(0); send_pair(1);
        send_bits({2'b00, ev_a[2]}, {2'b00, od_a[2]}, 5);
        check("pre_rst_tvalid", 34'(m_axis_tvalid), 34'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_tvalid", 34'(m_axis_tvalid), 34'd0);
        check("async_rst_line",   34'(line_cnt),      34'd0);
        tick();
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        got_base = got_q.size();
        for (int p = 3; p < 12; p++) send_pair(p);
        repeat (3) tick();
        check("post_rst_tvalid", 34'(m_axis_tvalid), 34'd0);
        compare_beats("post_rst");
        fill_random();
        model_pairs(1'b1, LP, 1'b1);
        send_line(SOF);
        repeat (4) tick();
        compare_beats("post_rst_sof");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_deser.md
SENSOR_DESER -- requirements
Module: sensor_deser

Interface
REQ-001 Parameter PIXEL_WIDTH, default 14: bits per pixel per lane.
REQ-002 Parameter LINE_PAIRS, default 80: pixel pairs (even+odd) per line.
REQ-003 Parameter FRAME_LINES, default 120: lines per frame.
REQ-004 Parameter SYNC_SOF, default 16'hFFF0: start-of-frame sync word, both lanes.
REQ-005 Parameter SYNC_SOL, default 16'hFFE0: start-of-line sync word, both lanes.
REQ-006 aclk  in  1  sole clock; all logic rising-edge.
REQ-007 aresetn  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronised to aclk.
REQ-008 sensor_ena  in  1  readout enable, synchronous to aclk.
REQ-009 sample_ena  in  1  one-cycle strobe per sensor bit time, from the clock-forward generator.
REQ-010 sensor_data_even  in  1  even-pixel serial lane, MSB first, pre-synchronised.
REQ-011 sensor_data_odd  in  1  odd-pixel serial lane, MSB first, pre-synchronised.
REQ-012 m_axis_tdata  out  32  {2'b0, odd[13:0], 2'b0, even[13:0]} (zero-padded to 16 bits per lane for any PIXEL_WIDTH <= 16).
REQ-013 m_axis_tvalid / m_axis_tready  out / in  1 / 1  AXI4-Stream handshake.
REQ-014 m_axis_tuser  out  1  first pair of a frame.
REQ-015 m_axis_tlast  out  1  last pair of a line.
REQ-016 line_cnt  out  8  index of the line currently being received, 0 to FRAME_LINES-1.
REQ-017 frame_done  out  1  one-cycle pulse after the last pair of line FRAME_LINES-1 is accepted into the FIFO.
REQ-018 overflow / trunc  out  1 / 1  sticky error flags.
REQ-019 err_clr  in  1  synchronous clear of both sticky flags.

Function
REQ-020 Both lanes SHALL be shifted into separate 16-bit shift registers only on cycles with sample_ena=1.
REQ-021 The FSM SHALL have the states IDLE, HUNT and PAYLOAD.
REQ-022 IDLE: shift registers SHALL be cleared; sensor_ena=1 SHALL move the FSM to HUNT.
REQ-023 HUNT: on a sample_ena cycle where both shift registers equal SYNC_SOF, the FSM SHALL move to PAYLOAD with line_cnt=0 and a pending tuser.
REQ-024 HUNT: if both registers equal SYNC_SOL, the FSM SHALL move to PAYLOAD with line_cnt unchanged.
REQ-025 HUNT: lane mismatch or any other value SHALL keep the FSM in HUNT.
REQ-026 PAYLOAD: a bit counter SHALL count 0 to PIXEL_WIDTH-1 and a pair counter 0 to LINE_PAIRS-1.
REQ-027 PAYLOAD: on the sample_ena cycle that captures the LSB, the completed pair SHALL be written into a 2-entry FIFO.
REQ-028 The completed pair SHALL be visible on m_axis_tvalid the next cycle if the FIFO was empty (latency 1 clock).
REQ-029 tuser SHALL be set on the first FIFO write after SOF; tlast on the write with pair=LINE_PAIRS-1.
REQ-030 After the tlast write the FSM SHALL return to HUNT and line_cnt SHALL increment; at FRAME_LINES-1 it SHALL wrap to 0 and assert frame_done.
REQ-031 A SOL seen when line_cnt has already wrapped (no SOF) SHALL be accepted normally; no tuser is emitted.
REQ-032 FIFO SHALL pop when m_axis_tvalid=1 and m_axis_tready=1; tdata/tuser/tlast SHALL be held stable while tvalid=1 and tready=0.
REQ-033 FIFO full and pair completion in the same cycle: if a pop occurs in that cycle the write SHALL succeed.
REQ-034 FIFO full and pair completion without a pop: the pair SHALL be dropped and overflow set; counters SHALL still advance, so tlast framing is preserved only for kept pairs.
REQ-035 sensor_ena=0 in HUNT or PAYLOAD: the FSM SHALL go to IDLE next cycle and the partial pixel SHALL be discarded.
REQ-036 sensor_ena=0 in PAYLOAD additionally SHALL set trunc; FIFO contents SHALL be retained and drained.
REQ-037 err_clr SHALL clear overflow/trunc; a same-cycle new error SHALL take priority and the flag remains set.

Reset
REQ-038 While aresetn=0: FSM=IDLE, FIFO empty, m_axis_tvalid=0, tdata=0, tuser=0, tlast=0.
REQ-039 While aresetn=0: line_cnt=0, frame_done=0, overflow=0, trunc=0, all counters and shift registers=0.
REQ-040 Reset asserted mid-line SHALL discard all in-flight data; no partial handshake SHALL follow reset release.

Verification
REQ-041 SOF, then 80 pairs of even=14'h0001..0050 and odd=14'h1001..1050, tready=1 -> 80 beats; beat0 tdata=32'h1001_0001 with tuser=1; beat79 tdata=32'h1050_0050 with tlast=1.
REQ-042 Full frame, SOF + 119 SOL lines -> 120 tlast, one frame_done pulse after line 119, line_cnt back to 0.
REQ-043 sample_ena every clock, tready=0 for 50 clocks -> exactly 2 pairs held, overflow=1, held tdata unchanged; err_clr -> overflow=0.
REQ-044 Even lane SOF, odd lane 16'h0000 -> FSM stays in HUNT, no tvalid.
REQ-045 sensor_ena dropped after pair 10, 7th bit -> 10 beats, no tlast, trunc=1, FSM=IDLE; a new SOF restarts cleanly.
REQ-046 aresetn pulsed low mid-pixel with tvalid=1 -> tvalid=0 immediately (asynchronously); after release, no output until the next sync.
